// File: rtl/data_memory_mmio.sv
// data_memory_mmio: word RAM plus LED/counter/compare/flag MMIO for a single-cycle CPU.
// Latency: reads are combinational, writes land on one edge; always ready, so there is no backpressure.
module data_memory_mmio #(
    parameter int RAM_ADDR_BITS = 8,
    parameter int LED_WIDTH     = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mem_write,
    input  logic [31:0]          address,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 timer_flag
);

    localparam int RAM_WORDS = 2 ** RAM_ADDR_BITS;

    logic [31:0]              ram_q [RAM_WORDS];
    logic [LED_WIDTH-1:0]     led_q, led_d;
    logic [31:0]              count_q, count_d;
    logic [31:0]              compare_q, compare_d;
    logic                     flag_q, flag_d;

    logic                     sel_ram, sel_mmio;
    logic [1:0]               reg_sel;
    logic [RAM_ADDR_BITS-1:0] ram_idx;
    logic                     ram_we, mmio_we, match;
    logic                     addr_unused;

    assign sel_ram     = (address[31:28] == 4'h0);
    assign sel_mmio    = (address[31:28] == 4'h1);
    assign reg_sel     = address[3:2];
    assign ram_idx     = address[RAM_ADDR_BITS+1:2];
    assign ram_we      = mem_write && !reset && sel_ram;
    assign mmio_we     = mem_write && sel_mmio;
    assign match       = (count_q == compare_q);
    assign addr_unused = ^{address[27:4], address[1:0]};

    always_comb begin
        led_d     = led_q;
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        flag_d    = flag_q;
        if (mmio_we) begin
            case (reg_sel)
                2'd0: led_d     = write_data[LED_WIDTH-1:0];
                2'd1: count_d   = write_data;
                2'd2: compare_d = write_data;
                default: begin
                    if (write_data[0]) flag_d = 1'b0;
                end
            endcase
        end
        // A match on the same edge as a software clear must leave the flag set.
        if (match) flag_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led_q     <= '0;
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            flag_q    <= 1'b0;
        end else begin
            led_q     <= led_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            flag_q    <= flag_d;
        end
    end

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (ram_we) ram_q[ram_idx] <= write_data;
    end

    always_comb begin
        read_data = '0;
        if (sel_ram) begin
            read_data = ram_q[ram_idx];
        end else if (sel_mmio) begin
            case (reg_sel)
                2'd0:    read_data = 32'(led_q);
                2'd1:    read_data = count_q;
                2'd2:    read_data = compare_q;
                default: read_data = {31'b0, flag_q};
            endcase
        end
    end

    assign leds       = led_q;
    assign timer_flag = flag_q;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio; expectations are queued at stimulus time
// and a negedge monitor pops and compares them against the live outputs.
module tb_data_memory_mmio;

    localparam int K_RD  = 0;
    localparam int K_LED = 1;
    localparam int K_FLG = 2;

    localparam logic [31:0] A_LED    = 32'h1000_0000;
    localparam logic [31:0] A_COUNT  = 32'h1000_0004;
    localparam logic [31:0] A_CMP    = 32'h1000_0008;
    localparam logic [31:0] A_STATUS = 32'h1000_000C;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic [7:0]  leds;
    logic        timer_flag;

    always #5 clock = ~clock;

    data_memory_mmio #(.RAM_ADDR_BITS(8), .LED_WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .leds       (leds),
        .timer_flag (timer_flag)
    );

    typedef struct {
        int          kind;
        logic [31:0] val;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;

    task automatic exp(input int kind, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.id   = next_id;
        next_id++;
        exp_q.push_back(e);
    endtask

    // One call = one cycle; inputs change just after the rising edge.
    task automatic drive(input logic rst, input logic we, input logic [31:0] a, input logic [31:0] d);
        @(posedge clock);
        #1;
        reset      = rst;
        mem_write  = we;
        address    = a;
        write_data = d;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] v);
        drive(1'b0, 1'b0, a, 32'h0);
        exp(K_RD, v);
    endtask

    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            string       nm;
            e = exp_q.pop_front();
            case (e.kind)
                K_RD:    begin act = read_data;           nm = "read_data";  end
                K_LED:   begin act = {24'h0, leds};       nm = "leds";       end
                default: begin act = {31'b0, timer_flag}; nm = "timer_flag"; end
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s #%0d: got 0x%08h expected 0x%08h at %0t", nm, e.id, act, e.val, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        drive(1'b1, 1'b0, A_COUNT, 32'h0);
        drive(1'b1, 1'b0, A_COUNT, 32'h0);
        exp(K_RD, 32'h0); exp(K_LED, 32'h0); exp(K_FLG, 32'h0);
        drive(1'b1, 1'b0, A_CMP, 32'h0);
        exp(K_RD, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, A_STATUS, 32'h0);
        exp(K_RD, 32'h0);

        // RAM write, read, alias, low bits ignored
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        wr(32'h0000_0014, 32'h0123_4567);
        rd(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0410, 32'hDEAD_BEEF);
        rd(32'h0000_0011, 32'hDEAD_BEEF);
        rd(32'h0000_0014, 32'h0123_4567);

        // LED register, MMIO aliasing, reset clears it
        wr(A_LED, 32'h0000_01A5);
        rd(A_LED, 32'h0000_00A5); exp(K_LED, 32'hA5);
        wr(32'h1ABC_DEF0, 32'h0000_003C);
        rd(A_LED, 32'h0000_003C); exp(K_LED, 32'h3C);
        drive(1'b1, 1'b0, A_LED, 32'h0);
        exp(K_LED, 32'h3C);
        rd(A_COUNT, 32'h0); exp(K_LED, 32'h0);
        rd(A_LED, 32'h0);

        // Counter load and wrap
        wr(A_COUNT, 32'hFFFF_FFFE);
        rd(A_COUNT, 32'hFFFF_FFFE);
        rd(A_COUNT, 32'hFFFF_FFFF);
        rd(A_COUNT, 32'h0000_0000);
        rd(A_COUNT, 32'h0000_0001);

        // Compare match: counter reads n in the n-th cycle after reset
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        wr(A_CMP, 32'd20);
        for (int n = 1; n <= 21; n++) begin
            rd(A_STATUS, (n >= 21) ? 32'h1 : 32'h0);
            exp(K_FLG, (n >= 21) ? 32'h1 : 32'h0);
        end
        wr(A_STATUS, 32'h0); exp(K_FLG, 32'h1);
        rd(A_STATUS, 32'h1); exp(K_FLG, 32'h1);
        wr(A_STATUS, 32'h1); exp(K_FLG, 32'h1);
        rd(A_STATUS, 32'h0); exp(K_FLG, 32'h0);

        // Set/clear collision: set wins
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        wr(A_COUNT, 32'd99);
        wr(A_CMP, 32'd100); exp(K_RD, 32'hFFFF_FFFF);
        wr(A_STATUS, 32'h1); exp(K_FLG, 32'h0);
        rd(A_STATUS, 32'h1); exp(K_FLG, 32'h1);
        wr(A_STATUS, 32'h1);
        rd(A_STATUS, 32'h0); exp(K_FLG, 32'h0);

        // Unmapped region: reads zero, writes dropped
        wr(32'h0000_0000, 32'hCAFE_F00D);
        wr(32'h2000_0000, 32'h1234_5678);
        rd(32'h2000_0000, 32'h0);
        rd(32'h0000_0000, 32'hCAFE_F00D);
        rd(32'h3000_0010, 32'h0);

        // Reset overrides concurrent writes
        wr(A_LED, 32'h0000_005A);
        drive(1'b1, 1'b1, A_LED, 32'h0000_00FF); exp(K_LED, 32'h5A);
        drive(1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111); exp(K_LED, 32'h0);
        rd(A_LED, 32'h0); exp(K_LED, 32'h0);
        rd(32'h0000_0010, 32'hDEAD_BEEF);

        drive(1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_mmio.md
Name: data_memory_mmio

Overview:
- Responder for the CPU's data-memory port. Takes mem_write, ALU_result as the address, and write_data. Returns read_data in the same cycle, as a single-cycle core requires.
- Holds a word-addressed data RAM and a small memory-mapped I/O block: LED register, free-running cycle counter, compare register and sticky match flag.
- Sits beside the instruction ROM in the SoC top and drives board LEDs and an interrupt-style flag.

Parameters:
- RAM_ADDR_BITS, 8, log2 of RAM depth in 32-bit words (256 words).
- LED_WIDTH, 8, number of LED register bits driven to the pins.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_write  input  1  write strobe from the CPU; acts on the rising edge.
- address  input  32  byte address from the CPU (ALU_result).
- write_data  input  32  store data from the CPU.
- read_data  output  32  load data, combinational from address.
- leds  output  LED_WIDTH  LED register contents.
- timer_flag  output  1  sticky compare-match flag.

Behaviour:
- Address decode uses address[31:28] and address[3:2]. address[1:0] is ignored; every access is a full 32-bit word.
- RAM region, address[31:28]==0x0: word index is address[RAM_ADDR_BITS+1:2]. Higher address bits inside the region alias (wrap).
- MMIO region, address[31:28]==0x1: address[27:4] ignored (aliases). Register selected by address[3:2]:
  - 0 LED: RW. Write stores write_data[LED_WIDTH-1:0]. Read returns it zero-extended.
  - 1 COUNT: RW. Read returns the current counter. Write loads write_data.
  - 2 COMPARE: RW, 32 bit.
  - 3 STATUS: read returns {31'b0, flag}. Write with write_data[0]==1 clears the flag; write with bit0==0 has no effect.
- Any other address[31:28]: reads return 0x0000_0000; writes are dropped.
- Read path: purely combinational. read_data reflects RAM/register contents before the current edge; there is no read-during-write bypass.
- Write path: on the rising edge with mem_write=1 and reset=0, the decoded target updates. The new value is visible on read_data in the following cycle.
- Counter:
  - Increments by 1 every cycle when reset=0.
  - Wraps from 0xFFFF_FFFF to 0x0000_0000.
  - A COUNT write takes priority over the increment: the next value equals write_data exactly.
- Match flag:
  - Sets on an edge where the pre-edge counter == COMPARE.
  - Stays set until cleared by software or reset.
  - If a set and a STATUS clear land on the same edge, set wins and the flag stays 1.
  - Comparison uses the current COMPARE, so a COMPARE write takes effect on the next edge.
- Reset, synchronous, while high:
  - Register values: LED=0, COUNT=0, COMPARE=0xFFFF_FFFF, flag=0.
  - Outputs follow: leds=0, timer_flag=0.
  - RAM contents are not reset (block RAM inference) and are undefined after power-up.
  - mem_write is ignored while reset is high.
  - read_data stays combinational throughout reset.
- Reset mid-operation: it overrides a concurrent write on the same edge. The counter restarts at 0 on the first edge after reset deasserts.
- Latency summary: read 0 cycles (combinational); write 1 edge; flag set 1 edge after the match condition.

Test Plan:
- RAM write/read/alias: write 0xDEADBEEF to 0x0000_0010, next cycle read 0x0000_0010 -> 0xDEADBEEF. With RAM_ADDR_BITS=8, read alias 0x0000_0410 -> 0xDEADBEEF; read 0x0000_0011 -> 0xDEADBEEF (low bits ignored).
- LED register: write 0x0000_01A5 to 0x1000_0000 -> leds=0xA5 next cycle; read 0x1000_0000 -> 0x0000_00A5. Assert reset for one edge -> leds=0x00.
- Counter load and wrap: write 0xFFFF_FFFE to 0x1000_0004. Reads on the following cycles -> 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000, 0x0000_0001.
- Compare match: after reset, write COMPARE=20. timer_flag rises on the edge where the pre-edge counter is 20 and stays high; STATUS read -> 0x1. Write 0x1 to 0x1000_000C -> flag=0. Write 0x0 to 0x1000_000C -> no change.
- Set/clear collision: load COUNT=99 and COMPARE=100, then time a STATUS clear for the edge where the counter is 100 -> timer_flag remains 1.
- Unmapped/reset write: write 0x1234_5678 to 0x2000_0000, then read it -> 0x0000_0000. Write LED=0xFF with reset=1 on the same edge -> leds=0x00.
